// File: rtl/servo_pwm_capture_avalon.sv
// Avalon-MM PWM capture: measures high time and period of the last complete
// cycle on pwm_in, in clock_clk cycles, with a coherent period shadow for reads.
module servo_pwm_capture_avalon #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clock_clk,
  input  logic        reset_low,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        pwm_in
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  typedef struct packed {
    logic rd;
    logic wr_sts;
    logic wr_ctrl;
  } bus_req_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt, hi_lat, high_time, period, period_shadow;
  logic             valid, timeout, overrun, enable;
  logic             pwm_m, pwm_s, pwm_d;
  logic             rise, fall, halt;
  bus_req_t         req;

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      pwm_m <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      pwm_m <= pwm_in;
      pwm_s <= pwm_m;
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  assign req.rd      = cs & read;
  assign req.wr_sts  = cs & write & (address == 2'd2);
  assign req.wr_ctrl = cs & write & (address == 2'd3);

  // A disabling CTRL write takes priority over an edge seen in the same cycle.
  assign halt = ~enable | (req.wr_ctrl & ~writedata[0]);

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (req.wr_sts) begin
        if (writedata[0]) valid   <= 1'b0;
        if (writedata[1]) timeout <= 1'b0;
        if (writedata[3]) overrun <= 1'b0;
      end
      // Flag sets below come later in the block so they beat a same-cycle clear.
      if (halt) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (rise) begin
            cnt   <= ONE;
            state <= HIGH;
          end
          HIGH: if (cnt == TMO) begin
            timeout <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + ONE;
            if (fall) begin
              hi_lat <= cnt;
              state  <= LOW;
            end
          end
          LOW: if (cnt == TMO) begin
            timeout <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else if (rise) begin
            period    <= cnt;
            high_time <= hi_lat;
            cnt       <= ONE;
            state     <= HIGH;
            valid     <= 1'b1;
            if (valid) overrun <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      readdata      <= '0;
      period_shadow <= '0;
      enable        <= 1'b1;
    end else begin
      if (req.wr_ctrl) enable <= writedata[0];
      if (req.rd) begin
        case (address)
          2'd0: begin
            readdata      <= 32'(high_time);
            period_shadow <= period;
          end
          2'd1:    readdata <= 32'(period_shadow);
          2'd2:    readdata <= {28'b0, overrun, pwm_s, timeout, valid};
          default: readdata <= {31'b0, enable};
        endcase
      end
    end
  end

  logic unused_wd;
  assign unused_wd = ^{writedata[31:4], writedata[2]};

endmodule

// File: tb/tb_servo_pwm_capture_avalon.sv
// Directed bench for servo_pwm_capture_avalon with TIMEOUT_CYCLES=1000.
module tb_servo_pwm_capture_avalon;

  logic        clock_clk = 1'b0;
  logic        reset_low = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        pwm_in = 1'b0;
  logic [31:0] rd;
  int          n_cmp = 0, n_err = 0;

  servo_pwm_capture_avalon #(.CNT_W(32), .TIMEOUT_CYCLES(1000)) dut (
    .clock_clk (clock_clk),
    .reset_low (reset_low),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .pwm_in    (pwm_in)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clock_clk);
    cs = 1'b1; read = 1'b1; address = a;
    @(negedge clock_clk);
    cs = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock_clk);
    cs = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clock_clk);
    cs = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic pwm_run(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      repeat (hi) @(negedge clock_clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clock_clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_clk);
  endtask

  initial begin
    // 1: reset state
    idle(3);
    reset_low = 1'b1;
    idle(2);
    bus_read(2'd0, rd); chk("rst_high", rd, 32'd0);
    bus_read(2'd1, rd); chk("rst_period", rd, 32'd0);
    bus_read(2'd2, rd); chk("rst_status", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst_ctrl", rd, 32'h1);

    // 2: three 100/300 periods -> two completions, overrun
    pwm_run(100, 300, 3);
    bus_read(2'd0, rd); chk("s2_high", rd, 32'd100);
    bus_read(2'd1, rd); chk("s2_period", rd, 32'd400);
    bus_read(2'd2, rd); chk("s2_status", rd, 32'h9);
    bus_write(2'd2, 32'h9);
    bus_read(2'd2, rd); chk("s2_w1c", rd, 32'h0);

    // 3: LOW timeout, then stuck-high timeout; results retained
    idle(1100);
    bus_read(2'd2, rd); chk("s3_low_tmo", rd, 32'h2);
    bus_write(2'd2, 32'h2);
    bus_read(2'd2, rd); chk("s3_tmo_clr", rd, 32'h0);
    pwm_in = 1'b1;
    idle(1200);
    bus_read(2'd2, rd); chk("s3_high_tmo", rd, 32'h6);
    bus_read(2'd0, rd); chk("s3_high_kept", rd, 32'd100);
    bus_read(2'd1, rd); chk("s3_period_kept", rd, 32'd400);
    pwm_in = 1'b0;
    idle(10);
    pwm_run(50, 150, 2);
    bus_read(2'd0, rd); chk("s3_high_50", rd, 32'd50);
    bus_read(2'd1, rd); chk("s3_period_200", rd, 32'd200);
    bus_read(2'd2, rd); chk("s3_status", rd, 32'h3);

    // 4: coherent period shadow across a new completion
    bus_write(2'd2, 32'hB);
    pwm_run(100, 300, 2);
    bus_read(2'd0, rd); chk("s4_high", rd, 32'd100);
    pwm_run(60, 190, 2);
    bus_read(2'd1, rd); chk("s4_shadow", rd, 32'd400);
    bus_read(2'd0, rd); chk("s4_high_new", rd, 32'd60);
    bus_read(2'd1, rd); chk("s4_period_new", rd, 32'd250);

    // 5: disable mid-pulse, then re-enable needs two rises
    fork
      pwm_run(60, 190, 4);
      begin
        idle(30);
        bus_write(2'd3, 32'h0);
        bus_write(2'd2, 32'hB);
      end
    join
    bus_read(2'd2, rd); chk("s5_no_update", rd, 32'h0);
    bus_read(2'd3, rd); chk("s5_ctrl_off", rd, 32'h0);
    bus_write(2'd3, 32'h1);
    fork
      pwm_run(70, 160, 2);
      begin
        idle(150);
        bus_read(2'd2, rd); chk("s5_one_rise", rd, 32'h0);
      end
    join
    bus_read(2'd0, rd); chk("s5_high", rd, 32'd70);
    bus_read(2'd1, rd); chk("s5_period", rd, 32'd230);
    bus_read(2'd2, rd); chk("s5_valid", rd, 32'h1);

    // 6: asynchronous reset mid-measurement
    fork
      pwm_run(100, 300, 2);
      begin
        idle(450);
        #2 reset_low = 1'b0;
        #1 chk("s6_async_rd", readdata, 32'h0);
        idle(3);
        reset_low = 1'b1;
      end
    join
    bus_read(2'd0, rd); chk("s6_high", rd, 32'd0);
    bus_read(2'd1, rd); chk("s6_period", rd, 32'd0);
    bus_read(2'd2, rd); chk("s6_status", rd, 32'h0);
    bus_read(2'd3, rd); chk("s6_ctrl", rd, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
